control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle fetch/decode/sequence controller that sits directly upstream of Datapath.
- Holds the program counter and fetches 32-bit instructions over a req/ack interface.
- Decodes each instruction into the Datapath control word (SA, SB, DA, FS, W, EN_B, EN_ALU, C_in, B_SEL, K).
- Latches the Datapath status flags and resolves branches.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- DATA_W, 64, datapath/constant/PC width.
- INSTR_W, 32, instruction width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_data  in  32  instruction word, valid when instr_ack=1.
- instr_ack  in  1  memory has returned instr_data for current instr_addr.
- status  in  4  Datapath flags {V,C,N,Z}.
- instr_req  out  1  fetch request.
- instr_addr  out  64  fetch address (= PC).
- SA  out  5  register A select.
- SB  out  5  register B select.
- DA  out  5  destination register.
- FS  out  5  ALU function select.
- W  out  1  register-file write enable.
- EN_B  out  1  B-bus driver enable.
- EN_ALU  out  1  ALU-to-bus enable.
- C_in  out  1  ALU carry-in.
- B_SEL  out  1  1 = K drives ALU B input, 0 = register B.
- K  out  64  sign-extended immediate.
- halted  out  1  processor stopped.
- illegal  out  1  stopped because of an undefined opcode.

Behaviour:
- Encoding: [31:26] op, [25:21] rd, [20:16] rn, [15:11] rm, [15:0] imm16. K = sign-extended imm16.
- Opcodes:
  - 00 NOP
  - 01 ADD rd=rn+rm
  - 02 SUB rd=rn-rm, sets flags
  - 03 AND
  - 04 ORR
  - 05 ADDI rd=rn+K
  - 06 SUBI rd=rn-K, sets flags
  - 07 MOVI rd=K
  - 08 B
  - 09 CBZ rd
  - 0A BCOND, cond in rd[1:0]: 0 EQ Z, 1 NE !Z, 2 LT N!=V, 3 GE N==V
  - 3F HALT
  - all others illegal
- FSM states: FETCH, DECODE, EXECUTE, PCUPD, HALT.
- FETCH: instr_req=1, instr_addr=PC. Stay until instr_ack=1, then latch IR and go to DECODE. Zero-wait memory gives a 1-cycle FETCH.
- DECODE: 1 cycle. Register control fields from IR. Control outputs stay idle.
- EXECUTE: 1 cycle. Control word is driven only in this state.
  - ALU ops: W=1, EN_ALU=1, EN_B=0.
  - SUB/SUBI: C_in=1, and flags<=status at the end of the cycle.
  - MOVI: SA=31 with ADD, B_SEL=1.
  - CBZ: SA=rd, SB=31, FS=ADD, W=0, EN_ALU=0. Branch taken if status.Z=1, sampled this cycle.
- PCUPD: 1 cycle.
  - Taken branch: PC <= PC + (sext(imm16)<<2).
  - Otherwise: PC <= PC+4.
  - Next state FETCH.
  - PC arithmetic wraps modulo 2^64.
- HALT: entered from EXECUTE on HALT (illegal=0) or an illegal opcode (illegal=1). PC is not updated. Absorbing state; only reset leaves.
- Latency: 4 cycles per instruction with zero-wait memory.
- Idle control word, driven in every non-EXECUTE cycle and on reset:
  - SA=SB=DA=31.
  - FS=FS_ADD.
  - W=0, EN_B=0, EN_ALU=0, C_in=0, B_SEL=0.
  - K=0.
- Other reset values: instr_req=0, halted=0, illegal=0, flags=0, PC=RESET_PC, state=FETCH. instr_req rises in the first cycle after reset deasserts.
- Reset mid-operation clears everything asynchronously. W drops immediately, with no partial write.
- instr_ack while instr_req=0 is ignored.
- Writes with DA=31 are issued as decoded; the register file discards them.
- Flags persist across non-flag-setting instructions.

Decomposition:
- Package cu_pkg holds:
  - opcode localparams (OP_ADD … OP_HALT);
  - FS constants: FS_AND=5'b00000, FS_ORR=5'b00100, FS_ADD=5'b01000, FS_SUB=5'b01001;
  - state encoding;
  - COND_EQ/NE/LT/GE;
  - ZR=5'd31.
- One sub-module, cu_decode, is natural: combinational IR-to-control-word mapping plus a legal flag. The FSM, PC and flags stay in control_unit.

Test Plan:
- Reset with RESET_PC=0, then release; memory acks next cycle with ADDI r1,r31,#5 → instr_addr=0, EXECUTE cycle shows DA=1, SA=31, B_SEL=1, K=5, W=1, FS=FS_ADD; PC=4 after PCUPD.
- Run SUB r2,r1,r1 with status=4'b0001 in EXECUTE, then BCOND EQ imm16=-2 at PC 8 → C_in=1, flags latched; next PC = 8-8 = 0.
- CBZ r3 imm16=3 at PC 0x10, status.Z=0 then a repeat with Z=1 → PC=0x14, then 0x1C.
- Hold instr_ack low for 5 cycles → instr_req stays 1, instr_addr stable, all control outputs idle, W=0.
- Opcode 0x2A → illegal=1, halted=1, PC frozen, instr_req=0 indefinitely; HALT opcode gives halted=1, illegal=0.
- Assert reset during EXECUTE of ADD → W falls asynchronously in the same cycle; PC=RESET_PC; fetch restarts at 0 after release.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the fetch/decode/sequence controller.
// Opcodes, ALU function selects, FSM states and control-word bundle.
package cu_pkg;

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_SUB   = 6'h02;
    localparam logic [5:0] OP_AND   = 6'h03;
    localparam logic [5:0] OP_ORR   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h05;
    localparam logic [5:0] OP_SUBI  = 6'h06;
    localparam logic [5:0] OP_MOVI  = 6'h07;
    localparam logic [5:0] OP_B     = 6'h08;
    localparam logic [5:0] OP_CBZ   = 6'h09;
    localparam logic [5:0] OP_BCOND = 6'h0A;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    localparam logic [1:0] COND_EQ = 2'd0;
    localparam logic [1:0] COND_NE = 2'd1;
    localparam logic [1:0] COND_LT = 2'd2;
    localparam logic [1:0] COND_GE = 2'd3;

    localparam logic [4:0] ZR = 5'd31;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_PCUPD,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_UNCOND,
        BR_CBZ,
        BR_COND
    } br_t;

    typedef struct packed {
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] da;
        logic [4:0] fs;
        logic       w;
        logic       en_b;
        logic       en_alu;
        logic       c_in;
        logic       b_sel;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c.sa     = ZR;
        c.sb     = ZR;
        c.da     = ZR;
        c.fs     = FS_ADD;
        c.w      = 1'b0;
        c.en_b   = 1'b0;
        c.en_alu = 1'b0;
        c.c_in   = 1'b0;
        c.b_sel  = 1'b0;
        return c;
    endfunction

    // flags are {V,C,N,Z}
    function automatic logic cond_met(logic [1:0] cond, logic [3:0] f);
        logic r;
        r = 1'b0;
        unique case (cond)
            COND_EQ: r = f[0];
            COND_NE: r = ~f[0];
            COND_LT: r = f[1] ^ f[3];
            COND_GE: r = ~(f[1] ^ f[3]);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction-register to control-word mapping.
// Also classifies branches, halts and undefined opcodes.
module cu_decode
    import cu_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] i_ir,
    output ctrl_t              o_ctrl,
    output logic [DATA_W-1:0]  o_k,
    output logic               o_legal,
    output logic               o_halt,
    output logic               o_set_flags,
    output br_t                o_br
);

    logic [5:0]        w_op;
    logic [4:0]        w_rd;
    logic [4:0]        w_rn;
    logic [4:0]        w_rm;
    logic [DATA_W-1:0] w_sext;

    assign w_op   = i_ir[31:26];
    assign w_rd   = i_ir[25:21];
    assign w_rn   = i_ir[20:16];
    assign w_rm   = i_ir[15:11];
    assign w_sext = {{(DATA_W-16){i_ir[15]}}, i_ir[15:0]};

    always_comb begin
        o_ctrl      = ctrl_idle();
        o_k         = '0;
        o_legal     = 1'b1;
        o_halt      = 1'b0;
        o_set_flags = 1'b0;
        o_br        = BR_NONE;
        case (w_op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                o_ctrl.sa     = w_rn;
                o_ctrl.sb     = w_rm;
                o_ctrl.da     = w_rd;
                o_ctrl.w      = 1'b1;
                o_ctrl.en_alu = 1'b1;
                unique case (1'b1)
                    w_op == OP_SUB: o_ctrl.fs = FS_SUB;
                    w_op == OP_AND: o_ctrl.fs = FS_AND;
                    w_op == OP_ORR: o_ctrl.fs = FS_ORR;
                    default:        o_ctrl.fs = FS_ADD;
                endcase
                o_ctrl.c_in = (w_op == OP_SUB);
                o_set_flags = (w_op == OP_SUB);
            end
            OP_ADDI, OP_SUBI, OP_MOVI: begin
                // MOVI is ZR + K through the adder
                o_ctrl.sa     = (w_op == OP_MOVI) ? ZR : w_rn;
                o_ctrl.da     = w_rd;
                o_ctrl.fs     = (w_op == OP_SUBI) ? FS_SUB : FS_ADD;
                o_ctrl.c_in   = (w_op == OP_SUBI);
                o_ctrl.b_sel  = 1'b1;
                o_ctrl.w      = 1'b1;
                o_ctrl.en_alu = 1'b1;
                o_k           = w_sext;
                o_set_flags   = (w_op == OP_SUBI);
            end
            OP_B:     o_br = BR_UNCOND;
            OP_CBZ: begin
                o_ctrl.sa = w_rd;
                o_ctrl.sb = ZR;
                o_br      = BR_CBZ;
            end
            OP_BCOND: o_br = BR_COND;
            OP_HALT:  o_halt = 1'b1;
            default:  o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/sequence controller driving the Datapath.
// Holds PC, IR and latched status flags; one instruction per 4 cycles.
module control_unit
    import cu_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               instr_ack,
    input  logic [3:0]         status,
    output logic               instr_req,
    output logic [DATA_W-1:0]  instr_addr,
    output logic [4:0]         SA,
    output logic [4:0]         SB,
    output logic [4:0]         DA,
    output logic [4:0]         FS,
    output logic               W,
    output logic               EN_B,
    output logic               EN_ALU,
    output logic               C_in,
    output logic               B_SEL,
    output logic [DATA_W-1:0]  K,
    output logic               halted,
    output logic               illegal
);

    state_t             r_state;
    logic [DATA_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic               r_req;
    logic               r_halted;
    logic               r_illegal;
    logic [3:0]         r_flags;
    logic               r_taken;
    ctrl_t              r_ctrl;
    logic [DATA_W-1:0]  r_k;

    ctrl_t              w_ctrl;
    logic [DATA_W-1:0]  w_k;
    logic               w_legal;
    logic               w_halt;
    logic               w_set_flags;
    br_t                w_br;
    logic               w_taken;
    logic [DATA_W-1:0]  w_offset;

    cu_decode #(
        .DATA_W  (DATA_W),
        .INSTR_W (INSTR_W)
    ) u_dec (
        .i_ir        (r_ir),
        .o_ctrl      (w_ctrl),
        .o_k         (w_k),
        .o_legal     (w_legal),
        .o_halt      (w_halt),
        .o_set_flags (w_set_flags),
        .o_br        (w_br)
    );

    // CBZ looks at live status; BCOND at flags latched by an earlier SUB/SUBI
    always_comb begin
        w_taken = 1'b0;
        unique case (w_br)
            BR_NONE:   w_taken = 1'b0;
            BR_UNCOND: w_taken = 1'b1;
            BR_CBZ:    w_taken = status[0];
            BR_COND:   w_taken = cond_met(r_ir[22:21], r_flags);
        endcase
    end

    assign w_offset = {{(DATA_W-18){r_ir[15]}}, r_ir[15:0], 2'b00};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_req     <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_flags   <= '0;
            r_taken   <= 1'b0;
            r_ctrl    <= ctrl_idle();
            r_k       <= '0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (instr_ack) begin
                        r_ir    <= instr_data;
                        r_req   <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_ctrl  <= w_ctrl;
                    r_k     <= w_k;
                    r_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    r_ctrl <= ctrl_idle();
                    r_k    <= '0;
                    if (!w_legal || w_halt) begin
                        r_halted  <= 1'b1;
                        r_illegal <= ~w_legal;
                        r_state   <= S_HALT;
                    end else begin
                        if (w_set_flags) r_flags <= status;
                        r_taken <= w_taken;
                        r_state <= S_PCUPD;
                    end
                end
                S_PCUPD: begin
                    r_pc    <= r_taken ? r_pc + w_offset
                                       : r_pc + DATA_W'(4);
                    r_req   <= 1'b1;
                    r_state <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
            endcase
        end
    end

    assign instr_req  = r_req;
    assign instr_addr = r_pc;
    assign SA         = r_ctrl.sa;
    assign SB         = r_ctrl.sb;
    assign DA         = r_ctrl.da;
    assign FS         = r_ctrl.fs;
    assign W          = r_ctrl.w;
    assign EN_B       = r_ctrl.en_b;
    assign EN_ALU     = r_ctrl.en_alu;
    assign C_in       = r_ctrl.c_in;
    assign B_SEL      = r_ctrl.b_sel;
    assign K          = r_k;
    assign halted     = r_halted;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
// Hand-encoded instructions with hand-computed PCs and control words.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_data = '0;
    logic        instr_ack = 1'b0;
    logic [3:0]  status = '0;
    logic        instr_req;
    logic [63:0] instr_addr;
    logic [4:0]  SA, SB, DA, FS;
    logic        W, EN_B, EN_ALU, C_in, B_SEL;
    logic [63:0] K;
    logic        halted, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0]  F_ADD = 5'b01000;
    localparam logic [4:0]  F_SUB = 5'b01001;
    localparam logic [88:0] IDLE  =
        {5'd31, 5'd31, 5'd31, 5'b01000, 5'b00000, 64'd0};

    control_unit #(.RESET_PC(64'd0)) dut (
        .clock      (clock),
        .reset      (reset),
        .instr_data (instr_data),
        .instr_ack  (instr_ack),
        .status     (status),
        .instr_req  (instr_req),
        .instr_addr (instr_addr),
        .SA         (SA),
        .SB         (SB),
        .DA         (DA),
        .FS         (FS),
        .W          (W),
        .EN_B       (EN_B),
        .EN_ALU     (EN_ALU),
        .C_in       (C_in),
        .B_SEL      (B_SEL),
        .K          (K),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [88:0] cw();
        return {SA, SB, DA, FS, W, EN_B, EN_ALU, C_in, B_SEL, K};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins);
        int k;
        k = 0;
        while (instr_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_tests++;
        if (instr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_timeout instr_req=%b required 1", instr_req);
        end
        instr_data = ins;
        instr_ack  = 1'b1;
        tick();
        instr_ack  = 1'b0;
        instr_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (cw() !== IDLE) begin
            n_fail++;
            $display("FAIL reset_cw got %h required %h", cw(), IDLE);
        end
        n_tests++;
        if ({instr_req, halted, illegal, instr_addr} !== {3'b000, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_state got %b%b%b %h required 000 0",
                     instr_req, halted, illegal, instr_addr);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if ({instr_req, instr_addr} !== {1'b1, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_req_rise got %b %h required 1 0",
                     instr_req, instr_addr);
        end
    endtask

    task automatic test_addi();
        fetch(32'h143F0005);
        n_tests++;
        if (cw() !== IDLE) begin
            n_fail++;
            $display("FAIL addi_decode_idle got %h required %h", cw(), IDLE);
        end
        tick();
        n_tests++;
        if ({DA, SA, B_SEL, W, EN_ALU, EN_B, C_in, FS, K} !==
            {5'd1, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, F_ADD, 64'd5}) begin
            n_fail++;
            $display("FAIL addi_exec DA=%0d SA=%0d BSEL=%b W=%b FS=%b K=%h required 1 31 1 1 01000 5",
                     DA, SA, B_SEL, W, FS, K);
        end
        tick();
        n_tests++;
        if ({W, instr_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL addi_pcupd W=%b req=%b required 0 0", W, instr_req);
        end
        tick();
        n_tests++;
        if ({instr_req, instr_addr} !== {1'b1, 64'd4}) begin
            n_fail++;
            $display("FAIL addi_nextpc got %b %h required 1 4",
                     instr_req, instr_addr);
        end
    endtask

    task automatic test_sub_bcond();
        status = 4'b0001;
        fetch(32'h08410800);
        tick();
        n_tests++;
        if ({SA, SB, DA, FS, C_in, W, EN_ALU, B_SEL} !==
            {5'd1, 5'd1, 5'd2, F_SUB, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_exec SA=%0d SB=%0d DA=%0d FS=%b Cin=%b W=%b required 1 1 2 01001 1 1",
                     SA, SB, DA, FS, C_in, W);
        end
        tick();
        status = 4'b0000;
        tick();
        n_tests++;
        if (instr_addr !== 64'd8) begin
            n_fail++;
            $display("FAIL sub_nextpc got %h required 8", instr_addr);
        end
        fetch(32'h2800FFFE);
        tick();
        n_tests++;
        if (cw() !== IDLE) begin
            n_fail++;
            $display("FAIL bcond_exec_idle got %h required %h", cw(), IDLE);
        end
        tick();
        tick();
        n_tests++;
        if (instr_addr !== 64'd0) begin
            n_fail++;
            $display("FAIL bcond_eq_taken got %h required 0", instr_addr);
        end
    endtask

    task automatic test_cbz();
        for (int i = 0; i < 4; i++) begin
            fetch(32'h0000_0000);
            repeat (3) tick();
        end
        n_tests++;
        if (instr_addr !== 64'h10) begin
            n_fail++;
            $display("FAIL nop_walk got %h required 10", instr_addr);
        end
        status = 4'b0000;
        fetch(32'h24600003);
        tick();
        n_tests++;
        if ({SA, SB, FS, W, EN_ALU} !== {5'd3, 5'd31, F_ADD, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL cbz_exec SA=%0d SB=%0d FS=%b W=%b EN_ALU=%b required 3 31 01000 0 0",
                     SA, SB, FS, W, EN_ALU);
        end
        tick();
        tick();
        n_tests++;
        if (instr_addr !== 64'h14) begin
            n_fail++;
            $display("FAIL cbz_not_taken got %h required 14", instr_addr);
        end
        fetch(32'h2000FFFF);
        repeat (3) tick();
        n_tests++;
        if (instr_addr !== 64'h10) begin
            n_fail++;
            $display("FAIL b_back got %h required 10", instr_addr);
        end
        status = 4'b0001;
        fetch(32'h24600003);
        tick();
        tick();
        status = 4'b0000;
        tick();
        n_tests++;
        if (instr_addr !== 64'h1C) begin
            n_fail++;
            $display("FAIL cbz_taken got %h required 1c", instr_addr);
        end
    endtask

    task automatic test_fetch_wait();
        instr_data = 32'h08410800;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({instr_req, instr_addr, cw()} !== {1'b1, 64'h1C, IDLE}) begin
                n_fail++;
                $display("FAIL fetch_wait[%0d] req=%b addr=%h cw=%h required 1 1c %h",
                         i, instr_req, instr_addr, cw(), IDLE);
            end
            tick();
        end
        instr_data = '0;
    endtask

    task automatic test_flags_persist();
        status = 4'b0000;
        fetch(32'h04811000);
        tick();
        n_tests++;
        if ({SA, SB, DA, FS, B_SEL, W, EN_ALU, C_in} !==
            {5'd1, 5'd2, 5'd4, F_ADD, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_exec SA=%0d SB=%0d DA=%0d FS=%b W=%b Cin=%b required 1 2 4 01000 1 0",
                     SA, SB, DA, FS, W, C_in);
        end
        tick();
        tick();
        fetch(32'h28200004);
        repeat (3) tick();
        n_tests++;
        if (instr_addr !== 64'h24) begin
            n_fail++;
            $display("FAIL bcond_ne_not_taken got %h required 24", instr_addr);
        end
        fetch(32'h28600002);
        repeat (3) tick();
        n_tests++;
        if (instr_addr !== 64'h2C) begin
            n_fail++;
            $display("FAIL bcond_ge_taken got %h required 2c", instr_addr);
        end
        fetch(32'h28400004);
        repeat (3) tick();
        n_tests++;
        if (instr_addr !== 64'h30) begin
            n_fail++;
            $display("FAIL bcond_lt_not_taken got %h required 30", instr_addr);
        end
    endtask

    task automatic test_async_reset();
        fetch(32'h04811000);
        tick();
        n_tests++;
        if (W !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_W got %b required 1", W);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({cw(), instr_req, instr_addr} !== {IDLE, 1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL rst_async W=%b cw=%h req=%b addr=%h required 0 %h 0 0",
                     W, cw(), instr_req, instr_addr, IDLE);
        end
        #3;
        reset = 1'b1;
        tick();
        n_tests++;
        if ({instr_req, instr_addr} !== {1'b1, 64'd0}) begin
            n_fail++;
            $display("FAIL rst_restart got %b %h required 1 0",
                     instr_req, instr_addr);
        end
        fetch(32'h0000_0000);
        repeat (3) tick();
        n_tests++;
        if (instr_addr !== 64'd4) begin
            n_fail++;
            $display("FAIL rst_first_instr got %h required 4", instr_addr);
        end
    endtask

    task automatic test_illegal();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        fetch(32'hA8000000);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({halted, illegal, instr_req, instr_addr, cw()} !==
                {3'b110, 64'd0, IDLE}) begin
                n_fail++;
                $display("FAIL illegal_hold[%0d] h=%b il=%b req=%b addr=%h required 1 1 0 0",
                         i, halted, illegal, instr_req, instr_addr);
            end
            instr_ack = 1'b1;
            tick();
            instr_ack = 1'b0;
        end
    endtask

    task automatic test_halt();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        fetch(32'hFC000000);
        tick();
        n_tests++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exec halted=%b required 0", halted);
        end
        repeat (4) tick();
        n_tests++;
        if ({halted, illegal, instr_req, instr_addr} !== {3'b100, 64'd0}) begin
            n_fail++;
            $display("FAIL halt_state h=%b il=%b req=%b addr=%h required 1 0 0 0",
                     halted, illegal, instr_req, instr_addr);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub_bcond();
        test_cbz();
        test_fetch_wait();
        test_flags_persist();
        test_async_reset();
        test_illegal();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
